// File: rtl/spi_slave_responder_if.sv
// Bundle of SPI pins and host-side tx/rx handshake for the SPI responder.
// slave: the responder's view; master: SPI master plus host driving it.
interface spi_slave_responder_if #(
    parameter int DATA_W = 8
);
    logic              SPI_CLK;
    logic              SPI_EN;
    logic              SPI_MOSI;
    logic              SPI_MISO;
    logic              miso_oe;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              underrun;
    logic              frame_err;

    modport slave (
        input  SPI_CLK, SPI_EN, SPI_MOSI, tx_data, tx_valid,
        output SPI_MISO, miso_oe, tx_ready, rx_data, rx_valid, underrun, frame_err
    );

    modport master (
        output SPI_CLK, SPI_EN, SPI_MOSI, tx_data, tx_valid,
        input  SPI_MISO, miso_oe, tx_ready, rx_data, rx_valid, underrun, frame_err
    );
endinterface

// File: rtl/spi_slave_responder.sv
// SPI mode-0 target, MSB first, oversampled on clk. Streams bytes within one
// SPI_EN-low frame; a one-entry holding register supplies the MISO response.
module spi_slave_responder #(
    parameter int              DATA_W      = 8,
    parameter int              SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_TX   = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_slave_responder_if.slave  bus
);
    localparam int CW = $clog2(DATA_W);

    typedef enum logic {IDLE, ACTIVE} state_e;
    state_e state, state_nx;

    logic [SYNC_STAGES-1:0] sclk_sync, en_sync, mosi_sync, fill;
    logic sclk_s, en_s, mosi_s, sclk_d, en_d, armed;
    logic sclk_rise, sclk_fall, en_rise, en_fall;

    logic [DATA_W-1:0] hold, shift_tx, shift_rx, rx_data;
    logic              hold_full, wrap_pend, urun_pend;
    logic              rx_done, rx_valid, underrun, frame_err;
    logic [CW-1:0]     bit_cnt;

    logic start_word, shift_fall, rise_act, abort, load;

    // The EN chain resets to "deselected"; armed blocks a false EN fall when
    // reset releases while the pin is already low, until a real high is seen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync <= '0;
            en_sync   <= '1;
            mosi_sync <= '0;
            fill      <= '0;
            sclk_d    <= 1'b0;
            en_d      <= 1'b1;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.SPI_CLK};
            en_sync   <= {en_sync[SYNC_STAGES-2:0], bus.SPI_EN};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.SPI_MOSI};
            fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
            sclk_d    <= sclk_s;
            en_d      <= en_s;
            armed     <= armed | (fill[SYNC_STAGES-1] & en_s);
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign en_s      = en_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign en_fall   = armed & en_d & ~en_s;
    assign en_rise   = en_s & ~en_d;
    assign load      = bus.tx_valid & ~hold_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // A fall after a completed word is the next word's start; an EN rise on
    // the same cycle wins so the holding register is not drained at frame end.
    always_comb begin
        state_nx   = state;
        start_word = 1'b0;
        shift_fall = 1'b0;
        rise_act   = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (en_fall) begin
                    state_nx   = ACTIVE;
                    start_word = 1'b1;
                end
            end
            ACTIVE: begin
                if (en_rise) begin
                    state_nx = IDLE;
                    abort    = 1'b1;
                end else begin
                    start_word = sclk_fall & wrap_pend;
                    shift_fall = sclk_fall & ~wrap_pend;
                    rise_act   = sclk_rise;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Underrun is reported at the first rise of a word, so the speculative
    // start after a frame's last byte never reports one if EN then rises.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold      <= '0;
            hold_full <= 1'b0;
            shift_tx  <= IDLE_TX;
            shift_rx  <= '0;
            bit_cnt   <= '0;
            wrap_pend <= 1'b0;
            urun_pend <= 1'b0;
            rx_data   <= '0;
            rx_done   <= 1'b0;
            rx_valid  <= 1'b0;
            underrun  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_done   <= 1'b0;
            rx_valid  <= rx_done;
            underrun  <= 1'b0;
            frame_err <= 1'b0;
            if (start_word) begin
                wrap_pend <= 1'b0;
                urun_pend <= ~hold_full & ~bus.tx_valid;
                if (hold_full) begin
                    shift_tx  <= hold;
                    hold_full <= 1'b0;
                end else if (bus.tx_valid) begin
                    shift_tx <= bus.tx_data;
                end else begin
                    shift_tx <= IDLE_TX;
                end
            end else begin
                if (load) begin
                    hold      <= bus.tx_data;
                    hold_full <= 1'b1;
                end
                if (shift_fall) shift_tx <= {shift_tx[DATA_W-2:0], 1'b1};
            end
            if (rise_act) begin
                shift_rx <= {shift_rx[DATA_W-2:0], mosi_s};
                if (bit_cnt == '0 && urun_pend) begin
                    underrun  <= 1'b1;
                    urun_pend <= 1'b0;
                end
                if (bit_cnt == CW'(DATA_W-1)) begin
                    bit_cnt   <= '0;
                    rx_data   <= {shift_rx[DATA_W-2:0], mosi_s};
                    rx_done   <= 1'b1;
                    wrap_pend <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            if (abort) begin
                frame_err <= (bit_cnt != '0);
                bit_cnt   <= '0;
                wrap_pend <= 1'b0;
                urun_pend <= 1'b0;
                shift_tx  <= IDLE_TX;
            end
        end
    end

    assign bus.SPI_MISO  = shift_tx[DATA_W-1];
    assign bus.miso_oe   = ~en_s;
    assign bus.tx_ready  = ~hold_full;
    assign bus.rx_data   = rx_data;
    assign bus.rx_valid  = rx_valid;
    assign bus.underrun  = underrun;
    assign bus.frame_err = frame_err;
endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: byte-level SPI master plus host model; rx
// words are scoreboarded, MISO bytes and pulse counts checked per frame.
module tb_spi_slave_responder;
    localparam int DW   = 8;
    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spi_slave_responder_if #(.DATA_W(DW)) bus();

    spi_slave_responder #(.DATA_W(DW), .SYNC_STAGES(2), .IDLE_TX(8'hFF)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0, n_bad = 0;
    int urun_seen = 0, ferr_seen = 0, rx_seen = 0;
    int exp_urun = 0, exp_ferr = 0, exp_rx = 0;
    logic [7:0] rx_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected word whenever the DUT reports one
    always @(negedge clk) begin
        if (rst) begin
            if (bus.rx_valid) begin
                rx_seen++;
                if (rx_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rx_unexpected: got %02h expected none", bus.rx_data);
                end else begin
                    check("rx_data", bus.rx_data, rx_q.pop_front());
                end
            end
            if (bus.underrun)  urun_seen++;
            if (bus.frame_err) ferr_seen++;
        end
    end

    task automatic half();
        repeat (HALF) @(negedge clk);
    endtask

    task automatic load(input logic [7:0] d);
        int t = 0;
        while (!bus.tx_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("tx_ready_wait", bus.tx_ready, 1);
        bus.tx_valid = 1'b1;
        bus.tx_data  = d;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic xfer_byte(input logic [7:0] mo, input logic ld_next, input logic [7:0] nw,
                             output logic [7:0] mi);
        for (int b = 7; b >= 0; b--) begin
            bus.SPI_MOSI = mo[b];
            half();
            mi[b] = bus.SPI_MISO;
            bus.SPI_CLK = 1'b1;
            half();
            bus.SPI_CLK = 1'b0;
            if (b == 5 && ld_next) load(nw);
        end
    endtask

    task automatic checkpoint(input string tag);
        check({tag, "_underruns"}, urun_seen, exp_urun);
        check({tag, "_frame_errs"}, ferr_seen, exp_ferr);
        check({tag, "_rx_count"}, rx_seen, exp_rx);
    endtask

    // Reference: byte i of a frame returns the host word queued for it, else 0xFF plus an underrun
    task automatic frame(input int n, input logic [7:0] mo[4], input logic ld[4],
                         input logic [7:0] tw[4], input logic en_low);
        logic [7:0] mi;
        if (!en_low) begin
            if (ld[0]) load(tw[0]);
            bus.SPI_EN = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            rx_q.push_back(mo[i]);
            exp_rx++;
            if (!ld[i]) exp_urun++;
            xfer_byte(mo[i], (i + 1 < n) && ld[(i + 1) % 4], tw[(i + 1) % 4], mi);
            check("miso_byte", mi, ld[i] ? tw[i] : 8'hFF);
        end
        half();
        bus.SPI_EN = 1'b1;
        half();
        half();
    endtask

    task automatic partial(input int nbits, input logic [7:0] mo);
        bus.SPI_EN = 1'b0;
        for (int b = 7; b > 7 - nbits; b--) begin
            bus.SPI_MOSI = mo[b];
            half();
            bus.SPI_CLK = 1'b1;
            half();
            bus.SPI_CLK = 1'b0;
        end
        half();
        bus.SPI_EN = 1'b1;
        exp_ferr++;
        exp_urun++;
        half();
        half();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_ready"}, bus.tx_ready, 1);
        check({tag, "_rx_valid"}, bus.rx_valid, 0);
        check({tag, "_underrun"}, bus.underrun, 0);
        check({tag, "_frame_err"}, bus.frame_err, 0);
        check({tag, "_miso_oe"}, bus.miso_oe, 0);
        check({tag, "_miso"}, bus.SPI_MISO, 1);
        check({tag, "_rx_data"}, bus.rx_data, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] mo[4], tw[4];
        logic       ld[4];
        int         t;

        bus.SPI_CLK = 1'b0; bus.SPI_EN = 1'b1; bus.SPI_MOSI = 1'b0;
        bus.tx_valid = 1'b0; bus.tx_data = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Loaded response A5 against incoming 3C
        frame(1, '{8'h3C, 8'h00, 8'h00, 8'h00}, '{1'b1, 1'b0, 1'b0, 1'b0},
              '{8'hA5, 8'h00, 8'h00, 8'h00}, 1'b0);
        checkpoint("t2");
        // Nothing loaded: idle word and one underrun
        frame(1, '{8'h00, 8'h00, 8'h00, 8'h00}, '{1'b0, 1'b0, 1'b0, 1'b0},
              '{8'h00, 8'h00, 8'h00, 8'h00}, 1'b0);
        checkpoint("t3");
        // Streaming three bytes, two responses supplied
        frame(3, '{8'h11, 8'h22, 8'h33, 8'h00}, '{1'b1, 1'b1, 1'b0, 1'b0},
              '{8'h01, 8'h02, 8'h00, 8'h00}, 1'b0);
        checkpoint("t4");
        // Aborted after 5 bits, then a clean frame
        partial(5, 8'hC7);
        checkpoint("t5a");
        frame(1, '{8'h5A, 8'h00, 8'h00, 8'h00}, '{1'b0, 1'b0, 1'b0, 1'b0},
              '{8'h00, 8'h00, 8'h00, 8'h00}, 1'b0);
        checkpoint("t5b");

        // SCLK activity while deselected is ignored
        for (int b = 0; b < 8; b++) begin
            bus.SPI_MOSI = 1'($urandom);
            half();
            bus.SPI_CLK = 1'b1;
            half();
            bus.SPI_CLK = 1'b0;
        end
        half();
        checkpoint("t6a");
        check("t6a_miso_oe", bus.miso_oe, 0);

        // Host word offered on the exact word-start cycle
        bus.SPI_EN = 1'b0;
        t = 0;
        while (!bus.miso_oe && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("t6b_oe_rise", bus.miso_oe, 1);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hC3;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        check("t6b_tx_ready_now", bus.tx_ready, 1);
        repeat (3) @(negedge clk);
        check("t6b_tx_ready_later", bus.tx_ready, 1);
        frame(1, '{8'hE7, 8'h00, 8'h00, 8'h00}, '{1'b1, 1'b0, 1'b0, 1'b0},
              '{8'hC3, 8'h00, 8'h00, 8'h00}, 1'b1);
        checkpoint("t6b");

        // Randomized frames and occasional aborts
        for (int f = 0; f < 16; f++) begin
            if ($urandom_range(0, 4) == 0) begin
                partial(int'($urandom_range(1, 7)), 8'($urandom));
            end else begin
                for (int i = 0; i < 4; i++) begin
                    mo[i] = 8'($urandom);
                    tw[i] = 8'($urandom);
                    ld[i] = 1'($urandom);
                end
                frame(int'($urandom_range(1, 3)), mo, ld, tw, 1'b0);
            end
            checkpoint("rand");
        end

        // Reset in the middle of a frame, EN still low afterwards
        load(8'h77);
        bus.SPI_EN = 1'b0;
        for (int b = 0; b < 3; b++) begin
            bus.SPI_MOSI = 1'($urandom);
            half();
            bus.SPI_CLK = 1'b1;
            half();
            bus.SPI_CLK = 1'b0;
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            bus.SPI_MOSI = 1'($urandom);
            half();
            bus.SPI_CLK = 1'b1;
            half();
            bus.SPI_CLK = 1'b0;
        end
        half();
        bus.SPI_EN = 1'b1;
        half();
        half();
        checkpoint("t1_after_rst");
        frame(1, '{8'h96, 8'h00, 8'h00, 8'h00}, '{1'b1, 1'b0, 1'b0, 1'b0},
              '{8'h4B, 8'h00, 8'h00, 8'h00}, 1'b0);
        checkpoint("t1_fresh");

        check("rx_queue_drained", rx_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
